// File: rtl/v810_cache_pkg.sv
// Shared definitions for the V810 cache controllers: state encoding, default geometry
// and address slicing helpers.
package v810_cache_pkg;

  localparam int unsigned C_LINES   = 128;
  localparam int unsigned C_WPL     = 2;
  localparam int unsigned C_RAM_LAT = 2;
  localparam int unsigned OFF_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT_WAIT,
    ST_FILL,
    ST_BYPASS,
    ST_CLEAR
  } cache_state_e;

  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int unsigned wpl);
    return (addr >> OFF_W) & 32'(wpl - 1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned lines,
                                             input int unsigned wpl);
    return (addr >> (OFF_W + $clog2(wpl))) & 32'(lines - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned lines,
                                           input int unsigned wpl);
    return addr >> (OFF_W + $clog2(wpl) + $clog2(lines));
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned wpl);
    return addr & ~32'(wpl * 4 - 1);
  endfunction

endpackage

// File: rtl/v810_dataram.sv
// Word store for the instruction cache: one write port, one read port whose data
// appears RAM_LAT clock edges after the read address.
module v810_dataram #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 32,
  parameter int unsigned RAM_LAT    = 2
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_address,
  input  logic [data_width-1:0] wr_data,
  input  logic [addr_width-1:0] rd_address,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem_q  [1 << addr_width];
  logic [data_width-1:0] pipe_q [RAM_LAT];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_address] <= wr_data;
    pipe_q[0] <= mem_q[rd_address];
    for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rd_data = pipe_q[RAM_LAT-1];

endmodule

// File: rtl/v810_icache_ctrl.sv
// V810 instruction cache controller: direct-mapped lookup, in-order line fill,
// uncached pass-through and whole-cache invalidate.
//
// state     | meaning
// ST_IDLE   | waiting for a request or a (pending) clear
// ST_LOOKUP | tag compare, dataram read issued
// ST_HIT_WAIT | waiting out the dataram read latency
// ST_FILL   | fetching every word of the line from the bus
// ST_BYPASS | single uncached bus read
// ST_CLEAR  | one-cycle invalidate of all lines
module v810_icache_ctrl
  import v810_cache_pkg::*;
#(
  parameter int unsigned LINES          = C_LINES,
  parameter int unsigned WORDS_PER_LINE = C_WPL,
  parameter int unsigned RAM_LAT        = C_RAM_LAT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  output logic        clear_busy,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WORD_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = 32 - OFF_W - WORD_W - IDX_W;
  localparam int unsigned RAM_AW = IDX_W + WORD_W;
  localparam int unsigned CNT_W  = $clog2(RAM_LAT + 1);

  cache_state_e      state_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] fill_word_q;
  logic [31:0]       capt_q;
  logic [CNT_W-1:0]  wait_q;
  logic              clear_pend_q;
  logic              cpu_ack_q;
  logic [31:0]       cpu_rdata_q;
  logic              rdata_sel_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic              clear_busy_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [LINES];

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] wrd;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              last_word;
  logic              ram_wr_en;
  logic [31:0]       ram_rd_data;

  assign idx       = IDX_W'(addr_index(addr_q, LINES, WORDS_PER_LINE));
  assign wrd       = WORD_W'(addr_word(addr_q, WORDS_PER_LINE));
  assign tag       = TAG_W'(addr_tag(addr_q, LINES, WORDS_PER_LINE));
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign last_word = (fill_word_q == WORD_W'(WORDS_PER_LINE - 1));
  assign ram_wr_en = (state_q == ST_FILL) && mem_ack;

  v810_dataram #(
    .addr_width (RAM_AW),
    .data_width (32),
    .RAM_LAT    (RAM_LAT)
  ) u_ram (
    .clock      (clock),
    .wr_en      (ram_wr_en),
    .wr_address ({idx, fill_word_q}),
    .wr_data    (mem_rdata),
    .rd_address ({idx, wrd}),
    .rd_data    (ram_rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      fill_word_q  <= '0;
      capt_q       <= '0;
      wait_q       <= '0;
      clear_pend_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      rdata_sel_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      clear_busy_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      cpu_ack_q    <= 1'b0;
      rdata_sel_q  <= 1'b0;
      clear_busy_q <= 1'b0;
      // Hit data is shown straight from the RAM in the ack cycle, then held here.
      if (rdata_sel_q) cpu_rdata_q <= ram_rd_data;
      if (clear && state_q != ST_IDLE && state_q != ST_CLEAR) clear_pend_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (clear || clear_pend_q) begin
            clear_pend_q <= 1'b0;
            clear_busy_q <= 1'b1;
            state_q      <= ST_CLEAR;
          end else if (cpu_req && !cpu_ack_q) begin
            addr_q <= cpu_addr;
            if (enable) begin
              state_q <= ST_LOOKUP;
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= cpu_addr & ~32'h3;
              state_q    <= ST_BYPASS;
            end
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            if (RAM_LAT < 2) begin
              cpu_ack_q   <= 1'b1;
              rdata_sel_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              wait_q  <= CNT_W'(RAM_LAT - 2);
              state_q <= ST_HIT_WAIT;
            end
          end else begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= line_base(addr_q, WORDS_PER_LINE);
            fill_word_q <= '0;
            state_q     <= ST_FILL;
          end
        end
        ST_HIT_WAIT: begin
          if (wait_q == '0) begin
            cpu_ack_q   <= 1'b1;
            rdata_sel_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            wait_q <= wait_q - CNT_W'(1);
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            if (fill_word_q == wrd) capt_q <= mem_rdata;
            if (last_word) begin
              mem_req_q    <= 1'b0;
              valid_q[idx] <= 1'b1;
              tag_q[idx]   <= tag;
              cpu_ack_q    <= 1'b1;
              cpu_rdata_q  <= (fill_word_q == wrd) ? mem_rdata : capt_q;
              state_q      <= ST_IDLE;
            end else begin
              mem_addr_q  <= mem_addr_q + 32'd4;
              fill_word_q <= fill_word_q + WORD_W'(1);
            end
          end
        end
        ST_BYPASS: begin
          if (mem_ack) begin
            mem_req_q   <= 1'b0;
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= mem_rdata;
            state_q     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          valid_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = rdata_sel_q ? ram_rd_data : cpu_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_v810_icache_ctrl.sv
// Bench for v810_icache_ctrl: scripted reads against a bus model whose data is a fixed
// function of the address; expected read data and bus addresses are queued per request.
module tb_v810_icache_ctrl;

  localparam int M_HIT  = 0;
  localparam int M_MISS = 1;
  localparam int M_BYP  = 2;

  logic        clock = 1'b0;
  logic        reset, enable, clear, cpu_req, mem_ack;
  logic [31:0] cpu_addr, mem_rdata;
  logic        clear_busy, cpu_ack, mem_req;
  logic [31:0] cpu_rdata, mem_addr;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          lat;
  bit          mem_stall = 1'b0;
  logic [31:0] exp_data_q [$];
  logic [31:0] exp_mem_q  [$];

  v810_icache_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .clear_busy (clear_busy),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (dut.u_ram.wr_en) wr_cnt++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus model: acks each request after 0..2 extra cycles and checks the address.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req && !mem_stall && !reset) begin
        lat = $urandom_range(0, 2);
        repeat (lat) @(negedge clock);
        if (mem_req && !mem_stall && !reset) begin
          if (exp_mem_q.size() == 0) check_val("mem_unexp", 32'(exp_mem_q.size()), 32'd1);
          else check_val("mem_addr", mem_addr, exp_mem_q.pop_front());
          mem_rdata = mem_word(mem_addr);
          mem_ack   = 1'b1;
          @(negedge clock);
          mem_ack   = 1'b0;
        end
      end
    end
  end

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_val("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int mode);
    int          cyc;
    bit          got;
    int          w0;
    logic [31:0] base;
    repeat (2) @(negedge clock);
    w0   = wr_cnt;
    base = a & ~32'h7;
    exp_data_q.push_back(mem_word(a & ~32'h3));
    if (mode == M_MISS) begin
      exp_mem_q.push_back(base);
      exp_mem_q.push_back(base + 32'd4);
    end else if (mode == M_BYP) begin
      exp_mem_q.push_back(a & ~32'h3);
    end
    cpu_addr = a;
    cpu_req  = 1'b1;
    cyc      = 0;
    got      = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clock);
      cyc++;
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    if (got) begin
      check_val("rdata", cpu_rdata, exp_data_q.pop_front());
    end else begin
      check_val("ack_timeout", 32'(cyc), 32'd0);
      void'(exp_data_q.pop_front());
      exp_mem_q.delete();
    end
    if (mode == M_HIT) check_val("hit_lat", 32'(cyc), 32'd3);
    check_val("fill_left", 32'(exp_mem_q.size()), 32'd0);
    check_val("ram_writes", 32'(wr_cnt - w0), (mode == M_MISS) ? 32'd2 : 32'd0);
  endtask

  task automatic wait_mem_req(input string tag);
    int cyc;
    cyc = 0;
    while (!mem_req && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    if (!mem_req) check_val(tag, 32'(cyc), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    clear    = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;

    // cold fill, then hit with fixed latency
    reset_dut();
    do_read(32'h1000, M_MISS);
    do_read(32'h1000, M_HIT);

    // requested word is the second of the line
    reset_dut();
    do_read(32'h1004, M_MISS);

    // conflict on the same index replaces the line
    do_read(32'h1000, M_HIT);
    do_read(32'h1400, M_MISS);
    do_read(32'h1404, M_HIT);
    do_read(32'h1000, M_MISS);

    // uncached pass-through leaves the cache untouched
    enable = 1'b0;
    do_read(32'h2000, M_BYP);
    do_read(32'h2004, M_BYP);
    enable = 1'b1;
    do_read(32'h2000, M_MISS);
    do_read(32'h2004, M_HIT);

    // clear during a fill is deferred until the fill has been acknowledged
    do_read(32'h5008, M_MISS);
    do_read(32'h500C, M_HIT);
    fork
      do_read(32'h1000, M_MISS);
      begin
        wait_mem_req("clr_wait_req");
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
      end
    join
    @(negedge clock);
    check_val("clr_busy_on", {31'd0, clear_busy}, 32'd1);
    check_val("clr_ack_pulse", {31'd0, cpu_ack}, 32'd0);
    @(negedge clock);
    check_val("clr_busy_off", {31'd0, clear_busy}, 32'd0);
    do_read(32'h1000, M_MISS);
    do_read(32'h5008, M_MISS);

    // reset with a fill outstanding
    repeat (2) @(negedge clock);
    mem_stall = 1'b1;
    cpu_addr  = 32'h3000;
    cpu_req   = 1'b1;
    wait_mem_req("rst_wait_req");
    check_val("rst_fill_addr", mem_addr, 32'h3000);
    reset = 1'b1;
    @(negedge clock);
    check_val("rst_fill_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_fill_ack", {31'd0, cpu_ack}, 32'd0);
    check_val("rst_fill_maddr", mem_addr, 32'd0);
    reset     = 1'b0;
    cpu_req   = 1'b0;
    mem_stall = 1'b0;
    do_read(32'h3000, M_MISS);
    do_read(32'h3004, M_HIT);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
